// File: rtl/lc3_pkg.sv
// Shared state encodings, opcode constants and opcode classification helpers
// for the LC-3 instruction sequencer.
package lc3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_UNUSED    = 3'd7
  } state_e;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_BR   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD   = 4'b0010;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
  localparam logic [OP_W-1:0] OP_JSR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
  localparam logic [OP_W-1:0] OP_LDR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_STR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_RTI  = 4'b1000;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
  localparam logic [OP_W-1:0] OP_LDI  = 4'b1010;
  localparam logic [OP_W-1:0] OP_STI  = 4'b1011;
  localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
  localparam logic [OP_W-1:0] OP_RES  = 4'b1101;
  localparam logic [OP_W-1:0] OP_LEA  = 4'b1110;
  localparam logic [OP_W-1:0] OP_TRAP = 4'b1111;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_indirect(input logic [OP_W-1:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic needs_wb(input logic [OP_W-1:0] op);
    return is_load(op) || (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
           (op == OP_LEA) || (op == OP_JSR);
  endfunction

endpackage

// File: rtl/lc3_dwell_cnt.sv
// Loadable down-counter timing FETCH and MEMORY dwell; done_c flags zero.
module lc3_dwell_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_c = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load)        cnt_d = load_val;
    else if (!done_c) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lc3_control.sv
// LC-3 instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// registered per-stage enables and a retired-instruction counter.
module lc3_control
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       opCode_in,
  output logic             fetch_start,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             mem_we,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned DW_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  opcode_q, opcode_d;
  logic             acc2_q, acc2_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fetch_start_q, fetch_start_d;
  logic             decode_en_q, decode_en_d;
  logic             exec_en_q, exec_en_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic             wb_en_q, wb_en_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             dwell_load_c, dwell_done_c, retire_c;

  lc3_dwell_cnt #(.W(DW_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load_c),
    .load_val (DWELL_LOAD),
    .done_c   (dwell_done_c)
  );

  // Next state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    acc2_d       = acc2_q;
    illegal_d    = illegal_q;
    count_d      = count_q;
    dwell_load_c = 1'b0;
    retire_c     = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d      = ST_FETCH;
          dwell_load_c = 1'b1;
        end
      end
      ST_FETCH: begin
        if (dwell_done_c) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        opcode_d = opCode_in;
        if (opCode_in == OP_TRAP) begin
          state_d = ST_HALT;
        end else if ((opCode_in == OP_RTI) || (opCode_in == OP_RES)) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_mem_op(opcode_q)) begin
          state_d      = ST_MEMORY;
          dwell_load_c = 1'b1;
          acc2_d       = 1'b0;
          mem_en_d     = 1'b1;
          mem_we_d     = is_store(opcode_q) && !is_indirect(opcode_q);
        end else if (needs_wb(opcode_q)) begin
          state_d = ST_WRITEBACK;
        end else begin
          retire_c = 1'b1;
        end
      end
      ST_MEMORY: begin
        if (dwell_done_c) begin
          // Indirect ops chain a second access; only its write is real
          if (is_indirect(opcode_q) && !acc2_q) begin
            acc2_d       = 1'b1;
            dwell_load_c = 1'b1;
            mem_en_d     = 1'b1;
            mem_we_d     = is_store(opcode_q);
          end else if (is_load(opcode_q)) begin
            state_d = ST_WRITEBACK;
          end else begin
            retire_c = 1'b1;
          end
        end
      end
      ST_WRITEBACK: retire_c = 1'b1;
      ST_HALT:      state_d  = ST_HALT;
      default:      state_d  = ST_IDLE;
    endcase

    if (retire_c) begin
      count_d = count_q + CNT_W'(1);
      if (stop) begin
        state_d = ST_IDLE;
      end else begin
        state_d      = ST_FETCH;
        dwell_load_c = 1'b1;
      end
    end
  end

  assign fetch_start_d = (state_d == ST_FETCH) && (state_q != ST_FETCH);
  assign decode_en_d   = (state_d == ST_DECODE);
  assign exec_en_d     = (state_d == ST_EXECUTE);
  assign wb_en_d       = (state_d == ST_WRITEBACK);
  assign halted_d      = (state_d == ST_HALT);
  assign busy_d        = (state_d != ST_IDLE) && (state_d != ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      acc2_q        <= 1'b0;
      illegal_q     <= 1'b0;
      count_q       <= '0;
      fetch_start_q <= 1'b0;
      decode_en_q   <= 1'b0;
      exec_en_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      wb_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      acc2_q        <= acc2_d;
      illegal_q     <= illegal_d;
      count_q       <= count_d;
      fetch_start_q <= fetch_start_d;
      decode_en_q   <= decode_en_d;
      exec_en_q     <= exec_en_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      wb_en_q       <= wb_en_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign fetch_start = fetch_start_q;
  assign decode_en   = decode_en_q;
  assign exec_en     = exec_en_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign wb_en       = wb_en_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign state_out   = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control at MEM_LAT=2 with hand-derived cycle timing.
module tb_lc3_control;

  logic        clk, rst_n, start, stop;
  logic [3:0]  op;
  logic        fetch_start, decode_en, exec_en, mem_en, mem_we, wb_en;
  logic        busy, halted, illegal;
  logic [2:0]  state_out;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  lc3_control #(.MEM_LAT(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .opCode_in   (op),
    .fetch_start (fetch_start),
    .decode_en   (decode_en),
    .exec_en     (exec_en),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .wb_en       (wb_en),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .state_out   (state_out),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; op = 4'b0000;

    // Reset held with start=1
    step(5);
    chk("rst_state", 32'(state_out), 0);
    chk("rst_outs", 32'({fetch_start, decode_en, exec_en, mem_en, mem_we, wb_en, busy, halted, illegal}), 0);
    chk("rst_count", 32'(instr_count), 0);
    start = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("idle_no_fetch", 32'(fetch_start), 0);
      chk("idle_state", 32'(state_out), 0);
    end

    // ADD: 5-cycle period
    op = 4'b0001; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      chk("add_fetch", 32'(fetch_start), 32'(k % 5 == 1));
      chk("add_exec", 32'(exec_en), 32'(k % 5 == 4));
      chk("add_wb", 32'(wb_en), 32'(k % 5 == 0));
    end
    step(1);
    exp_count = 3;
    chk("add_count3", 32'(instr_count), 32'(exp_count));
    chk("add_fetch16", 32'(fetch_start), 1);
    stop = 1'b1;
    step(5);
    exp_count = 4;
    chk("add_stop_state", 32'(state_out), 0);
    chk("add_stop_busy", 32'(busy), 0);
    chk("add_stop_count", 32'(instr_count), 32'(exp_count));
    step(3);
    chk("stop_wins_idle", 32'(state_out), 0);
    chk("stop_wins_fetch", 32'(fetch_start), 0);
    stop = 1'b0; start = 1'b0;

    // BR: 4-cycle period
    op = 4'b0000; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("br_exec", 32'(exec_en), 32'(k == 4));
      chk("br_fetch", 32'(fetch_start), 32'(k == 1 || k == 5));
      chk("br_wb", 32'(wb_en), 0);
    end
    stop = 1'b1; start = 1'b0;
    step(4);
    exp_count += 2;
    chk("br_idle", 32'(state_out), 0);
    chk("br_count", 32'(instr_count), 32'(exp_count));
    stop = 1'b0;

    // LD with stop raised during MEMORY
    op = 4'b0010; start = 1'b1;
    step(5);
    chk("ld_mem_state", 32'(state_out), 4);
    chk("ld_mem_en", 32'(mem_en), 1);
    chk("ld_mem_we", 32'(mem_we), 0);
    stop = 1'b1; start = 1'b0;
    step(1);
    chk("ld_mem_hold", 32'(state_out), 4);
    chk("ld_mem_pulse", 32'(mem_en), 0);
    step(1);
    chk("ld_wb", 32'(wb_en), 1);
    chk("ld_wb_state", 32'(state_out), 5);
    step(1);
    exp_count += 1;
    chk("ld_idle", 32'(state_out), 0);
    chk("ld_busy", 32'(busy), 0);
    chk("ld_count", 32'(instr_count), 32'(exp_count));
    stop = 1'b0;

    // LDI: two reads, writeback, 9-cycle period
    op = 4'b1010; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("ldi_mem_en", 32'(mem_en), 32'(k == 5 || k == 7));
      chk("ldi_mem_we", 32'(mem_we), 0);
      chk("ldi_wb", 32'(wb_en), 32'(k == 9));
      chk("ldi_fetch", 32'(fetch_start), 32'(k == 1 || k == 10));
    end
    stop = 1'b1; start = 1'b0;
    step(9);
    exp_count += 2;
    chk("ldi_idle", 32'(state_out), 0);
    chk("ldi_count", 32'(instr_count), 32'(exp_count));
    stop = 1'b0;

    // STI: read then write, no writeback, 8-cycle period
    op = 4'b1011; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk("sti_mem_en", 32'(mem_en), 32'(k == 5 || k == 7));
      chk("sti_mem_we", 32'(mem_we), 32'(k == 7));
      chk("sti_wb", 32'(wb_en), 0);
      chk("sti_fetch", 32'(fetch_start), 32'(k == 1 || k == 9));
    end
    stop = 1'b1; start = 1'b0;
    step(8);
    exp_count += 2;
    chk("sti_idle", 32'(state_out), 0);
    chk("sti_count", 32'(instr_count), 32'(exp_count));
    stop = 1'b0;

    // TRAP halts without counting
    op = 4'b1111; start = 1'b1;
    step(3);
    chk("trap_decode", 32'(decode_en), 1);
    step(1);
    chk("trap_state", 32'(state_out), 6);
    chk("trap_halted", 32'(halted), 1);
    chk("trap_illegal", 32'(illegal), 0);
    chk("trap_busy", 32'(busy), 0);
    chk("trap_count", 32'(instr_count), 32'(exp_count));
    start = 1'b0; step(1);
    start = 1'b1; stop = 1'b1; step(2);
    chk("trap_sticky", 32'(state_out), 6);
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    chk("trap_rst_state", 32'(state_out), 0);
    chk("trap_rst_halted", 32'(halted), 0);
    chk("trap_rst_count", 32'(instr_count), 32'(exp_count));
    #1 rst_n = 1'b1;
    stop = 1'b0;

    // Reserved opcode halts with illegal
    op = 4'b1101; start = 1'b1;
    step(4);
    chk("res_state", 32'(state_out), 6);
    chk("res_illegal", 32'(illegal), 1);
    chk("res_halted", 32'(halted), 1);
    start = 1'b0; step(1);
    start = 1'b1; step(1);
    chk("res_sticky", 32'(state_out), 6);
    chk("res_illegal_hold", 32'(illegal), 1);
    rst_n = 1'b0;
    #1;
    chk("res_rst_illegal", 32'(illegal), 0);
    chk("res_rst_halted", 32'(halted), 0);
    #1 rst_n = 1'b1;

    // Asynchronous reset in the middle of MEMORY
    op = 4'b0010; start = 1'b1;
    step(5);
    chk("ar_mem_state", 32'(state_out), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state_out), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_mem_en", 32'(mem_en), 0);
    chk("ar_count", 32'(instr_count), 0);
    start = 1'b0;
    #1 rst_n = 1'b1;
    step(3);
    chk("ar_idle_after", 32'(state_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_control.md
Name: lc3_control

Overview:
- Top-level instruction sequencer for the LC-3 core. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives fetch_start into the fetch unit and produces per-stage enables for the decoder, ALU, memory port and register-file write.
- Opcode comes from the instruction register after fetch. Stage dwell times depend on a configurable BRAM read latency.

Parameters:
- MEM_LAT, 2, BRAM access latency in cycles (≥1); dwell of each FETCH or memory access.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; run program from IDLE.
- stop  in  1  level; return to IDLE at next instruction boundary.
- opCode_in  in  4  instruction[15:12], valid in DECODE.
- fetch_start  out  1  one-cycle pulse, first cycle of FETCH.
- decode_en  out  1  high in DECODE.
- exec_en  out  1  high in EXECUTE.
- mem_en  out  1  one-cycle pulse at start of each memory access.
- mem_we  out  1  high with mem_en on the final access of ST/STI/STR.
- wb_en  out  1  high in WRITEBACK.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on RTI (1000) or reserved (1101).
- state_out  out  3  current state encoding.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Clock and reset: clk single clock; rst_n asynchronous active-low. Reset forces state IDLE, all outputs 0, instr_count 0, latched opcode 0, dwell counter 0.
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
  - 7 is unreachable; if reached, next state is IDLE.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- IDLE: start=1 sampled at an edge → FETCH next cycle.
- FETCH:
  - Dwells exactly MEM_LAT cycles using a down-counter; fetch_start is high only in the first of those cycles.
  - Then → DECODE.
- DECODE:
  - One cycle; opcode latched from opCode_in.
  - TRAP (1111) → HALT.
  - RTI (1000) or 1101 → HALT, illegal set.
  - Otherwise → EXECUTE.
- EXECUTE: one cycle, then by latched opcode:
  - LD 0010, LDR 0110, LDI 1010, ST 0011, STR 0111, STI 1011 → MEMORY.
  - ADD 0001, AND 0101, NOT 1001, LEA 1110, JSR 0100 → WRITEBACK.
  - BR 0000, JMP 1100 → retire.
- MEMORY:
  - One access (MEM_LAT cycles) for LD/LDR/ST/STR; two back-to-back accesses (2*MEM_LAT cycles) for LDI/STI.
  - mem_en pulses in the first cycle of each access.
  - For STI, the first access is a read (mem_we=0) and the second is a write.
  - Loads → WRITEBACK; stores → retire.
- WRITEBACK: one cycle, then retire.
- Retire:
  - instr_count += 1 (wraps modulo 2^CNT_W).
  - next state = IDLE if stop=1 at that edge, else FETCH.
  - TRAP and illegal opcodes are not counted.
- stop is ignored mid-instruction; it takes effect only at retire. stop=1 in IDLE keeps IDLE even if start=1 (stop wins).
- HALT is sticky; only rst_n leaves it. start and stop are ignored in HALT.
- Cycle counts at MEM_LAT=2, measured from entering FETCH to next FETCH:
  - BR/JMP 4.
  - ADD/AND/NOT/LEA/JSR 5.
  - ST/STR 6.
  - LD/LDR 7.
  - STI 8.
  - LDI 9.
- Reset asserted mid-instruction aborts immediately to IDLE. The partial instruction is not counted; illegal is cleared.

Decomposition:
- Shared package lc3_pkg holds:
  - state enum/localparams (IDLE…HALT);
  - 4-bit opcode constants (OP_BR … OP_TRAP);
  - helper functions is_mem_op, is_load, is_indirect, needs_wb.
- Optional sub-module lc3_dwell_cnt: loadable down-counter with done flag, shared by FETCH and MEMORY dwell.

Test Plan:
- Reset:
  - Hold rst_n=0 5 cycles with start=1 → state_out=0, all outputs 0, instr_count=0.
  - Release with start=0 → stays IDLE, fetch_start never pulses.
- ADD run:
  - start=1 and opCode_in=0001 (held constant while start=1 and stop=0) → fetch_start pulses every 5 cycles; exec_en and wb_en each high 1 cycle per instruction.
  - instr_count=3 after 15 cycles.
- LDI vs STI, MEM_LAT=2:
  - LDI → 2 mem_en pulses 2 cycles apart, mem_we=0, wb_en follows, 9-cycle period.
  - STI → mem_we=1 only on second pulse, no wb_en, 8-cycle period.
- Stop mid-instruction: assert stop during MEMORY of LD → completes WRITEBACK, instr_count +1, then IDLE with busy=0.
- Halt and illegal:
  - opCode_in=1111 → HALT, halted=1, illegal=0, count unchanged.
  - opCode_in=1101 → HALT with illegal=1; start toggling has no effect; rst_n clears both.
- Async reset mid-MEMORY: drop rst_n between clock edges → outputs clear immediately without waiting for clk; count not incremented.
